instr_prefetch_buffer: RTL

- Decoupling stage between the instruction memory and the pipeline's Fetch/Decode boundary.
- Issues sequential word-fetch requests to a variable-latency, in-order instruction memory and buffers up to DEPTH returned instructions with their PCs.
- Delivers them to Decode under a valid/ready handshake.
- On a taken branch/jump redirect from Execute it discards buffered and in-flight (stale) instructions and restarts fetching at the target.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/prefetch_fifo.sv | 52 +++++
 rtl/instr_prefetch_buffer.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction prefetch buffer
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN,
    DRAIN
  } pf_state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - DEPTH-entry FIFO of fetched {pc, instr} pairs with synchronous clear
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         wr_en,
  input  fetch_entry_t wr_data,
  input  logic         rd_en,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;

  assign do_rd   = rd_en && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !do_rd) count <= count + CW'(1);
      else if (!wr_en && do_rd) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - sequential instruction prefetcher with redirect flush and stale-response drain
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  pf_state_t     state, state_next;
  logic [CW-1:0] outstanding, outstanding_next;
  logic [CW-1:0] drop_cnt, drop_next;
  logic [CW-1:0] live_out;
  logic [CW-1:0] count;
  logic [CW:0]   credit_sum;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   redirect_target;
  logic          req_fire;
  logic          deq_fire;
  logic          fifo_wr;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  head;

  // Stale responses still in flight do not need buffer space, only live ones do.
  assign live_out        = outstanding - drop_cnt;
  assign credit_sum      = {1'b0, count} + {1'b0, live_out};
  assign imem_req_valid  = reset && (credit_sum < DEPTH_W);
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign deq_fire        = instr_valid && instr_ready && !redirect_valid;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  always_comb begin
    state_next = state;
    drop_next  = drop_cnt;
    fifo_wr    = 1'b0;
    if (redirect_valid) begin
      drop_next  = outstanding_next;
      state_next = (outstanding_next != '0) ? DRAIN : RUN;
    end else begin
      case (state)
        RUN:   fifo_wr = imem_rsp_valid;
        DRAIN: begin
          if (imem_rsp_valid) begin
            drop_next = drop_cnt - CW'(1);
            if (drop_cnt == CW'(1)) state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (fifo_wr)  rsp_pc   <= rsp_pc + 32'd4;
      end
    end
  end

  // The credit check makes a write into a full, non-draining FIFO impossible.
  always_ff @(posedge clock) begin
    if (reset) assert (!(fifo_wr && fifo_full && !deq_fire));
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear   (redirect_valid),
    .wr_en   (fifo_wr),
    .wr_data ({rsp_pc, imem_rsp_data}),
    .rd_en   (deq_fire),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign instr_valid    = !fifo_empty;
  assign instr_data     = instr_valid ? head.instr : NOP_INSTR;
  assign instr_pc       = head.pc;
  assign instr_pc_plus4 = head.pc + 32'd4;

endmodule
